// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared opcodes, ALU encodings and the control-word type.
package pipe_ctrl_pkg;
  localparam int OP_NOP   = 0;
  localparam int OP_LOAD  = 1;
  localparam int OP_STORE = 2;
  localparam int OP_ADD   = 3;
  localparam int OP_NOT   = 4;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_NOT = 2'd1;
  localparam logic [1:0] ALU_NOP = 2'd2;
  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       wb;
  } ctrl_word_t;
  localparam ctrl_word_t NOP_WORD = '{valid: 1'b0, mem_read: 1'b0, mem_write: 1'b0, alu_op: ALU_NOP, wb: 1'b0};
endpackage

// File: rtl/pipe_ctrl_unit_decoder.sv
// ctrl_decoder: combinational opcode to control word, illegal flag and source usage.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          word,
  output logic                illegal,
  output logic                use_rs1,
  output logic                use_rs2
);
  int   op;
  logic is_load, is_store, is_add, is_not;
  assign op        = int'(opcode);
  assign is_load   = op == OP_LOAD;
  assign is_store  = op == OP_STORE;
  assign is_add    = op == OP_ADD;
  assign is_not    = op == OP_NOT;
  assign illegal   = op > OP_NOT;
  assign use_rs1   = is_add || is_store || is_not;
  assign use_rs2   = is_add || is_store;
  assign word.valid     = 1'b1;
  assign word.mem_read  = is_load;
  assign word.mem_write = is_store;
  assign word.alu_op    = is_add ? ALU_ADD : is_not ? ALU_NOT : ALU_NOP;
  assign word.wb        = is_load || is_add || is_not;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control-word pipeline with freeze, flush and load-use bubble insertion.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 3,
  parameter int REG_W    = 3,
  parameter int STAGES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_W-1:0]      rd,
  input  logic [REG_W-1:0]      rs1,
  input  logic [REG_W-1:0]      rs2,
  input  logic                  stall_in,
  input  logic                  flush,
  output logic                  in_ready,
  output logic                  hazard_stall,
  output logic                  illegal,
  output logic [STAGES-1:0]     st_valid,
  output logic [STAGES-1:0]     st_mem_read,
  output logic [STAGES-1:0]     st_mem_write,
  output logic [STAGES-1:0]     st_wb,
  output logic [2*STAGES-1:0]   st_alu_op
);
  ctrl_word_t       st [STAGES];
  ctrl_word_t       dec_word;
  logic             dec_illegal, use_rs1, use_rs2, accept;
  logic [REG_W-1:0] rd0;
  ctrl_decoder #(.OPCODE_W(OPCODE_W)) u_dec (
    .opcode (opcode),
    .word   (dec_word),
    .illegal(dec_illegal),
    .use_rs1(use_rs1),
    .use_rs2(use_rs2)
  );
  // a load in stage 0 cannot forward to the very next instruction
  assign hazard_stall = in_valid && st[0].valid && st[0].mem_read &&
                        ((use_rs1 && rs1 == rd0) || (use_rs2 && rs2 == rd0));
  assign in_ready = !stall_in && !hazard_stall && !flush;
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) st[i] <= NOP_WORD;
      rd0     <= '0;
      illegal <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++) st[i] <= NOP_WORD;
      illegal <= 1'b0;
    end else if (stall_in) begin
      illegal <= 1'b0;
    end else begin
      for (int i = 1; i < STAGES; i++) st[i] <= st[i-1];
      st[0]   <= accept ? dec_word : NOP_WORD;
      illegal <= accept && dec_illegal;
      if (accept) rd0 <= rd;
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_out
    assign st_valid[k]        = st[k].valid;
    assign st_mem_read[k]     = st[k].mem_read;
    assign st_mem_write[k]    = st[k].mem_write;
    assign st_wb[k]           = st[k].wb;
    assign st_alu_op[2*k +: 2] = st[k].alu_op;
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed vector table, hand sequences and random run against an opcode-level model.
module tb_pipe_ctrl_unit;
  localparam int S = 3;
  logic clk = 1'b0;
  logic rst, in_valid, stall_in, flush;
  logic [2:0] opcode, rd, rs1, rs2;
  logic in_ready, hazard_stall, illegal;
  logic [S-1:0] st_valid, st_mem_read, st_mem_write, st_wb;
  logic [2*S-1:0] st_alu_op;
  always #5 clk = ~clk;
  pipe_ctrl_unit #(.OPCODE_W(3), .REG_W(3), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .stall_in(stall_in), .flush(flush), .in_ready(in_ready), .hazard_stall(hazard_stall),
    .illegal(illegal), .st_valid(st_valid), .st_mem_read(st_mem_read), .st_mem_write(st_mem_write),
    .st_wb(st_wb), .st_alu_op(st_alu_op)
  );
  int  n_cmp = 0, n_bad = 0;
  bit  m_v [S];
  int  m_op [S];
  int  m_rd0;
  bit  m_ill;
  bit  last_rdy, last_haz;
  typedef struct {
    bit iv; int op, rd, rs1, rs2; bit st, fl, rdy, haz;
    logic [2:0] v, mr, wb; bit ill;
  } vec_t;
  vec_t tbl [17];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit reads1(input int op);
    return op == 2 || op == 3 || op == 4;
  endfunction
  function automatic bit reads2(input int op);
    return op == 2 || op == 3;
  endfunction
  function automatic bit m_haz(input bit iv, input int op, input int a, input int b);
    return iv && m_v[0] && m_op[0] == 1 && ((reads1(op) && a == m_rd0) || (reads2(op) && b == m_rd0));
  endfunction
  function automatic logic [63:0] exp_state();
    logic [2:0] v, mr, mw, wb;
    logic [5:0] alu;
    for (int i = 0; i < S; i++) begin
      v[i]  = m_v[i];
      mr[i] = m_op[i] == 1;
      mw[i] = m_op[i] == 2;
      wb[i] = m_op[i] == 1 || m_op[i] == 3 || m_op[i] == 4;
      alu[2*i +: 2] = m_op[i] == 3 ? 2'd0 : m_op[i] == 4 ? 2'd1 : 2'd2;
    end
    return {45'd0, m_ill, alu, wb, mw, mr, v};
  endfunction
  function automatic logic [63:0] act_state();
    return {45'd0, illegal, st_alu_op, st_wb, st_mem_write, st_mem_read, st_valid};
  endfunction
  task automatic m_reset();
    for (int i = 0; i < S; i++) begin
      m_v[i] = 1'b0;
      m_op[i] = 0;
    end
    m_rd0 = 0;
    m_ill = 1'b0;
  endtask
  task automatic step(input bit iv, input int op, input int rd_i, input int a, input int b,
                      input bit st_i, input bit fl_i);
    bit h, acc;
    in_valid = iv; opcode = 3'(op); rd = 3'(rd_i); rs1 = 3'(a); rs2 = 3'(b);
    stall_in = st_i; flush = fl_i;
    #1;
    h = m_haz(iv, op, a, b);
    last_rdy = in_ready;
    last_haz = hazard_stall;
    chk("hazard_stall", 64'(hazard_stall), 64'(h));
    chk("in_ready", 64'(in_ready), 64'(!st_i && !h && !fl_i));
    @(posedge clk);
    if (fl_i) begin
      for (int i = 0; i < S; i++) begin
        m_v[i] = 1'b0;
        m_op[i] = 0;
      end
      m_ill = 1'b0;
    end else if (st_i) begin
      m_ill = 1'b0;
    end else begin
      acc = iv && !h;
      for (int i = S - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_op[i] = m_op[i-1];
      end
      m_v[0] = acc;
      m_op[0] = acc ? op : 0;
      if (acc) m_rd0 = rd_i;
      m_ill = acc && op > 4;
    end
    #1;
    chk("stage_state", act_state(), exp_state());
  endtask
  initial begin
    tbl[0]  = '{1'b1, 3, 1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b001, 1'b0};
    tbl[1]  = '{1'b1, 4, 2, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b000, 3'b011, 1'b0};
    tbl[2]  = '{1'b1, 2, 0, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 3'b110, 1'b0};
    tbl[3]  = '{1'b1, 1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b001, 3'b101, 1'b0};
    tbl[4]  = '{1'b1, 3, 4, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b110, 3'b010, 3'b010, 1'b0};
    tbl[5]  = '{1'b1, 3, 4, 3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b100, 3'b101, 1'b0};
    tbl[6]  = '{1'b1, 1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b001, 3'b011, 1'b0};
    tbl[7]  = '{1'b1, 3, 4, 5, 6, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b010, 3'b111, 1'b0};
    tbl[8]  = '{1'b1, 6, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b100, 3'b110, 1'b1};
    tbl[9]  = '{1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 3'b000, 3'b100, 1'b0};
    tbl[10] = '{1'b1, 1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b001, 3'b001, 1'b0};
    tbl[11] = '{1'b1, 2, 0, 1, 2, 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0};
    tbl[12] = '{1'b1, 2, 0, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0};
    tbl[13] = '{1'b1, 3, 1, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0};
    tbl[14] = '{1'b1, 4, 5, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b000, 3'b001, 1'b0};
    tbl[15] = '{1'b1, 1, 2, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b001, 3'b011, 1'b0};
    tbl[16] = '{1'b1, 4, 6, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b010, 3'b111, 1'b0};
    rst = 1'b1; in_valid = 1'b0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    stall_in = 1'b0; flush = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act_state(), {45'd0, 1'b0, 6'b101010, 12'd0});
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].st, tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), 64'(last_rdy), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_hazard", i), 64'(last_haz), 64'(tbl[i].haz));
      chk($sformatf("tbl%0d_valid", i), 64'(st_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d_mem_read", i), 64'(st_mem_read), 64'(tbl[i].mr));
      chk($sformatf("tbl%0d_wb", i), 64'(st_wb), 64'(tbl[i].wb));
      chk($sformatf("tbl%0d_illegal", i), 64'(illegal), 64'(tbl[i].ill));
    end
    // asynchronous reset in the middle of a cycle with a full pipe
    #2 rst = 1'b1;
    #1;
    chk("async_reset_state", act_state(), {45'd0, 1'b0, 6'b101010, 12'd0});
    chk("async_reset_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("reset_held_state", act_state(), {45'd0, 1'b0, 6'b101010, 12'd0});
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3, i, 7, 7, 1'b0, 1'b0);
    chk("full_valid", 64'(st_valid), 64'd7);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4, 1, 2, 2, 1'b1, 1'b0);
      chk("stall_ready", 64'(last_rdy), 64'd0);
      chk("stall_hold_valid", 64'(st_valid), 64'd7);
    end
    step(1'b1, 4, 1, 2, 2, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control unit for the processor datapath. Decodes each accepted instruction into a control word {mem_read, mem_write, alu_op, wb} and carries it down a STAGES-deep register chain, one stage per cycle, exposing every stage's word to the datapath. Beyond plain buffering, it supports a downstream freeze (stall_in), a full pipeline flush, and automatic load-use hazard detection with bubble insertion. It sits between instruction fetch and the execute/memory/write-back stages.

## Interface
- OPCODE_W, 3, opcode width
- REG_W, 3, register-address width
- STAGES, 3, number of control-word stages (minimum 2)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction present on opcode/rd/rs1/rs2
- opcode  in  OPCODE_W  instruction opcode
- rd, rs1, rs2  in  REG_W each  destination / source register addresses
- stall_in  in  1  downstream freeze; holds all stages
- flush  in  1  squash all in-flight instructions
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- hazard_stall  out  1  load-use hazard detected this cycle
- illegal  out  1  registered pulse: accepted opcode was undefined
- st_valid  out  STAGES  per-stage valid; bit k = stage k
- st_mem_read, st_mem_write, st_wb  out  STAGES each  per-stage control bits
- st_alu_op  out  2*STAGES  per-stage ALU op; bits [2k+1:2k] = stage k

## Operation
- Decode: 1 LOAD -> mem_read=1, wb=1; 2 STORE -> mem_write=1; 3 ADD -> alu_op=0, wb=1; 4 NOT -> alu_op=1, wb=1; 0 and all others -> NOP word. alu_op=2 whenever the op is not ADD/NOT. Opcodes >4 set illegal and decode as NOP.
- wb = LOAD | ADD | NOT only; STORE and NOP never write back.
- Bubble/NOP word: valid=0, mem_read=0, mem_write=0, alu_op=2, wb=0.
- Source usage: ADD and STORE read rs1 and rs2; NOT reads rs1; LOAD and NOP read none.
- Hazard: hazard_stall = in_valid && stage 0 valid && stage 0 is LOAD && stage0.rd equals a source register read by the incoming op. The combinational hazard check is gated by the registered stage-0 state and the current inputs only.
- in_ready = !stall_in && !hazard_stall && !flush.
- Each edge, priority order:
  - flush: all stages become bubble and nothing is accepted. Flush wins over stall_in and hazard.
  - stall_in: all stages hold their contents, including valid bits.
  - hazard: stages 1..STAGES-1 shift, stage 0 loads a bubble, and the input is not accepted. Upstream holds the instruction.
  - normal: stage k <- stage k-1; stage 0 <- decoded input if in_valid, else bubble.
- Stage 0 also registers rd, for hazard comparison.
- The final stage's word is discarded on shift.

## Timing
- Reset (asynchronous, immediate): all st_valid=0, st_mem_read=0, st_mem_write=0, st_wb=0, every st_alu_op field=2, illegal=0, stored rd=0. in_ready follows its combinational equation.
- Latency: an instruction accepted at edge N appears in stage 0 after edge N and reaches stage k after edge N+k, excluding stalled cycles.
- A hazard costs exactly one bubble. On the next cycle the load has left stage 0, so the held instruction is accepted.
- illegal is high for exactly the cycle after acceptance and is 0 after flush or a stalled edge.
- Reset deasserting mid-stream: the pipeline restarts empty. There is no partial state.

## Structure
- Package pipe_ctrl_pkg contains:
  - opcode constants: OP_NOP, OP_LOAD, OP_STORE, OP_ADD, OP_NOT
  - ALU encodings: ALU_ADD=0, ALU_NOT=1, ALU_NOP=2
  - ctrl_word_t struct {valid, mem_read, mem_write, alu_op, wb}
  - a NOP_WORD constant
- Sub-module ctrl_decoder: purely combinational; maps opcode to ctrl_word_t, the illegal flag and the source-usage bits.
- Top level: the stage array, hazard compare, and priority logic.

## Test plan
- Reset asserted mid-stream with 3 valid stages -> all outputs cleared within the same cycle; every alu_op field=2.
- Stream ADD, NOT, STORE, LOAD with no stalls -> each word appears in stage k exactly k+1 cycles after acceptance. STORE has wb=0; LOAD has mem_read=1 and wb=1.
- LOAD rd=3 followed by ADD rs1=3 -> hazard_stall=1 and in_ready=0 for one cycle, a bubble in stage 0, then ADD accepted. ADD rs1=5 after the same LOAD -> no hazard.
- Hold stall_in for 2 cycles with the pipe full -> all stage outputs unchanged and in_ready=0; flow resumes unchanged afterwards.
- Assert flush together with stall_in and a pending hazard -> next cycle all st_valid=0, and the input is not accepted.
- Opcode 6 accepted -> illegal=1 for one cycle and a NOP word in stage 0 with valid=1.
